// File: rtl/pipe_buf_elastic_pkg.sv
// Shared types for the elastic pipeline buffer: FSM state encoding,
// default payload width and the stage payload struct carried through it.
// Combinational only; no latency and no backpressure of its own.
package Pipe_Buf_Reg_PKG;

    localparam int PIPE_DEF_WIDTH = 32;

    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [7:0]  tag;
        logic [23:0] pay;
    } stage_t;

endpackage

// File: rtl/pipe_buf_elastic_sat_counter.sv
// Saturating up-counter for back-pressured cycles; clr beats inc.
// Latency: count updates one cycle after inc/clr.
// Backpressure: none; it observes only.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_buf_elastic.sv
// Two-entry elastic buffer (main + skid register) with flush and a stall counter.
// Latency: 1 cycle from accept to out_data when empty; full throughput when streaming.
// Backpressure: in_ready is registered and drops only when both entries are held.
module pipe_buf_elastic
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int WIDTH = PIPE_DEF_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             stall_clr
);

    pipe_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             accept;
    logic             drain;

    assign accept    = in_valid && in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign drain     = out_valid && out_ready;
    assign in_ready  = in_ready_q;
    assign out_data  = main_q;
    assign occupancy = 2'(state_q);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    skid_d  = in_data;
                    state_d = TWO;
                end else if (accept && drain) begin
                    main_d  = in_data;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Payload loads under flush are harmless: contents are don't-care once empty.
        if (flush) begin
            state_d = EMPTY;
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid && !out_ready),
        .clr   (stall_clr),
        .count (stall_cnt)
    );

endmodule

// File: doc/pipe_buf_elastic.md
PIPE_BUF_ELASTIC -- requirements
Module: pipe_buf_elastic

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (legal range 1..256).
REQ-002 Parameter CNT_W, default 16, stall-counter width in bits (legal range 4..32).
REQ-003 The port list SHALL be:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  buffer accepts this cycle; driven from a register, no combinational path from out_ready.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  payload at head of buffer.
- flush  in  1  discard all contents (branch/jump kill).
- occupancy  out  2  number of held entries, 0..2.
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles.
- stall_clr  in  1  clears stall_cnt.

Function
REQ-004 Transfers: in_valid && in_ready is an accept; out_valid && out_ready is a drain.
REQ-005 Storage SHALL be a main register feeding out_data plus one skid register; no other payload storage.
REQ-006 FSM states: EMPTY (occupancy 0), ONE (1), TWO (2).
REQ-007 EMPTY: an accept loads main -> ONE.
REQ-008 ONE: accept without drain loads skid -> TWO; drain without accept -> EMPTY; accept with drain loads main -> ONE.
REQ-009 TWO: in_ready is 0, so no accept occurs; a drain moves skid to main -> ONE.
REQ-010 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, registered from the next state.
REQ-011 out_valid SHALL be 1 exactly in ONE and TWO; out_data SHALL be the main register.
REQ-012 Latency: data accepted in cycle N SHALL appear on out_data in cycle N+1 when the buffer was EMPTY.
REQ-013 Throughput: with out_ready held at 1, one transfer per cycle, with no bubble.
REQ-014 Ordering SHALL be strict FIFO; no payload is duplicated or lost except by flush.
REQ-015 flush has priority over accept and drain: the next state is EMPTY, and any same-cycle accepted payload is discarded.
REQ-016 While flush is high, in_ready in the following cycle SHALL be 1.
REQ-017 stall_cnt SHALL increment when out_valid && !out_ready.
REQ-018 stall_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-019 stall_clr SHALL zero stall_cnt next cycle, with priority over increment.
REQ-020 flush SHALL not alter stall_cnt.
REQ-021 Payload registers SHALL hold their value when not loaded; contents while out_valid=0 are don't-care.

Reset
REQ-022 With rst_n=0 at a clock edge, the block SHALL enter EMPTY with in_ready=1, out_valid=0, occupancy=0, stall_cnt=0, and out_data=0.
REQ-023 Reset mid-operation discards both entries; accept and drain in that cycle are ignored.
REQ-024 Reset SHALL have priority over flush and stall_clr.

Structure
REQ-025 The FSM state enum (EMPTY/ONE/TWO, 2 bits) and constant PIPE_DEF_WIDTH=32 SHALL live in the shared package Pipe_Buf_Reg_PKG.
REQ-026 The existing stage structs SHALL be carried by setting WIDTH=$bits(struct).
REQ-027 The saturating counter SHALL be the sub-module pipe_sat_counter (parameter CNT_W; inputs inc, clr; output count).

Verification
REQ-028 The bench SHALL cover these scenarios:
- Streaming: reset, then 8 words 0x1..0x8 with out_ready=1 -> outputs 0x1..0x8 on consecutive cycles, first word one cycle after its accept, stall_cnt=0.
- Back-pressure: accept 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0; then out_ready=1 -> 0xA then 0xB, stall_cnt counts the held cycles.
- Flush with accept: in TWO, assert flush while offering 0xC -> next cycle occupancy=0, out_valid=0, in_ready=1; 0xC never appears.
- Saturation: CNT_W=4, hold out_valid with out_ready=0 for 20 cycles -> stall_cnt=15 and stays 15; stall_clr -> 0 next cycle.
- Reset mid-stream: rst_n=0 for 1 cycle with occupancy=2 -> all outputs at reset values the next cycle; a fresh word 0x5 then passes with 1-cycle latency.
- Random: random in_valid/out_ready/flush for 10k cycles against a scoreboard queue -> no loss, duplication, or reordering except flush discards.
